// File: rtl/brake_ctrl.sv
// brake_ctrl: heartbeat watchdog with brake PWM drive.
// The host arms the watchdog with brake_heart_enable and keeps it alive
// with brake_heart_pulse. If no pulse arrives within the configured number
// of seconds, the block enters TIMEOUT and raises brake_fault.
// The PWM period always runs; its duty is taken from brake_ratio and is
// latched once at the start of each period.
// Optional build macro: BRAKE_FAILSAFE_EN drives full brake (constant-high
// PWM) while in TIMEOUT. When the macro is undefined, the PWM stays low in
// TIMEOUT.
module brake_ctrl #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned PWM_PERIOD = 1000,
    parameter int unsigned U_DLY      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        brake_heart_pulse,
    input  logic [7:0]  brake_heart_timeout,
    input  logic        brake_heart_enable,
    input  logic [15:0] brake_ratio,
    output logic        brake_pwm,
    output logic        brake_fault,
    output logic        brake_fault_int,
    output logic [1:0]  brake_state
);

    localparam int unsigned    CYC_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_FREQ - 1);
    localparam logic [15:0]    PWM_LAST = 16'(PWM_PERIOD - 1);
    localparam logic [15:0]    PWM_MAX  = 16'(PWM_PERIOD);

    // U_DLY is kept for interface compatibility; register updates here are zero-delay.
    if (U_DLY > 32'd1000000) begin : g_dly_unmodelled
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [7:0]         sec_q, sec_d;
    logic [15:0]        pwm_cnt_q, pwm_cnt_d;
    logic [15:0]        duty_q, duty_d;
    logic               pwm_q, pwm_d;
    logic               fault_q, fault_d;
    logic               fault_int_q, fault_int_d;

    logic               tick;
    logic [7:0]         eff_timeout;
    logic [8:0]         sec_inc;
    logic [15:0]        ratio_clip;
    logic [15:0]        duty_cur;

    // A zero timeout is treated as one second; the value is used live.
    assign eff_timeout = (brake_heart_timeout == 8'd0) ? 8'd1 : brake_heart_timeout;
    assign sec_inc     = {1'b0, sec_q} + 9'd1;
    assign tick        = (state_q == ST_ARMED) && (cyc_q == CYC_LAST);
    assign ratio_clip  = (brake_ratio > PWM_MAX) ? PWM_MAX : brake_ratio;

    // Next-state logic for the watchdog FSM and its cycle/second counters.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        sec_d   = sec_q;
        if (!brake_heart_enable) begin
            state_d = ST_IDLE;
            cyc_d   = '0;
            sec_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                    cyc_d   = '0;
                    sec_d   = '0;
                end
                ST_ARMED: begin
                    if (brake_heart_pulse) begin
                        // A pulse on the timeout tick still wins, so no fault is raised.
                        cyc_d = '0;
                        sec_d = '0;
                    end else if (tick) begin
                        cyc_d = '0;
                        if (sec_inc >= {1'b0, eff_timeout}) begin
                            state_d = ST_TIMEOUT;
                            sec_d   = '0;
                        end else begin
                            sec_d = sec_inc[7:0];
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                ST_TIMEOUT: begin
                    if (brake_heart_pulse) begin
                        state_d = ST_ARMED;
                        cyc_d   = '0;
                        sec_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cyc_d   = '0;
                    sec_d   = '0;
                end
            endcase
        end
    end

    // PWM counter, duty latch, and next values of the registered outputs.
    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 16'd0 : pwm_cnt_q + 16'd1;
        duty_d    = duty_q;
        duty_cur  = duty_q;
        if (pwm_cnt_q == 16'd0) begin
            duty_d   = ratio_clip;
            duty_cur = ratio_clip;
        end
        case (state_d)
            ST_ARMED: pwm_d = (pwm_cnt_q < duty_cur);
            ST_TIMEOUT: begin
`ifdef BRAKE_FAILSAFE_EN
                pwm_d = 1'b1;
`else
                pwm_d = 1'b0;
`endif
            end
            default: pwm_d = 1'b0;
        endcase
        fault_d     = (state_d == ST_TIMEOUT);
        fault_int_d = (state_d == ST_TIMEOUT) && (state_q != ST_TIMEOUT);
    end

    // All state, counters and outputs clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            sec_q       <= '0;
            pwm_cnt_q   <= '0;
            duty_q      <= '0;
            pwm_q       <= 1'b0;
            fault_q     <= 1'b0;
            fault_int_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            sec_q       <= sec_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_d;
            pwm_q       <= pwm_d;
            fault_q     <= fault_d;
            fault_int_q <= fault_int_d;
        end
    end

    assign brake_pwm       = pwm_q;
    assign brake_fault     = fault_q;
    assign brake_fault_int = fault_int_q;
    assign brake_state     = state_q;

endmodule
